// File: rtl/adc0809_emu.sv
// adc0809_emu: synthesizable responder model of an ADC0809-class 8-channel, 8-bit SAR ADC.
// Replaces the physical converter in FPGA loopback builds; sample values come from a fabric bus.
//
// Optional feature (macro ADC_EMU_RAMP_EN): samples come from an internal per-channel ramp
// register array that advances by RAMP_STEP after each completed conversion; ch_data is ignored.
//
// Ports:
//   clk       emulator clock (independent of the controller's adc_clk)
//   rst_n     asynchronous active-low reset
//   ale       address latch enable (synchronized internally)
//   addr      channel select ABC, 000 = IN0
//   start     conversion start pulse (synchronized internally)
//   oe        output enable (not synchronized)
//   ch_data   channel samples, IN[n] = ch_data[8n+7:8n]
//   eoc       end of conversion, high = idle/done
//   data_out  output latch contents
//   data_drv  pad drive enable, equal to oe
//   busy      high from synced start rise until conversion end
//   conv_cnt  completed conversion count, wraps

module adc0809_emu #(
  parameter int unsigned CONV_CYCLES = 64,
  parameter int unsigned EOC_DLY     = 8,
  parameter int unsigned RAMP_STEP   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ale,
  input  logic [2:0]  addr,
  input  logic        start,
  input  logic        oe,
  input  logic [63:0] ch_data,
  output logic        eoc,
  output logic [7:0]  data_out,
  output logic        data_drv,
  output logic        busy,
  output logic [15:0] conv_cnt
);

  localparam logic [7:0]  EocDly   = 8'(EOC_DLY);
  localparam logic [15:0] ConvLast = 16'(CONV_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StArm, StConvert} state_e;

  state_e      state_q, state_d;
  logic        ale_meta, ale_s;
  logic        start_meta, start_s, start_prev;
  logic        start_rise, start_fall;
  logic [2:0]  ch_q;
  logic [7:0]  dly_q, dly_d;
  logic [15:0] cnt_q, cnt_d;
  logic        eoc_q, eoc_d;
  logic        busy_q, busy_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] conv_cnt_q, conv_cnt_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  sample;
  logic        conv_done;

  // Two-flop synchronizers plus a history flop for edge detection on the synced start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ale_meta   <= 1'b0;
      ale_s      <= 1'b0;
      start_meta <= 1'b0;
      start_s    <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      ale_meta   <= ale;
      ale_s      <= ale_meta;
      start_meta <= start;
      start_s    <= start_meta;
      start_prev <= start_s;
    end
  end

  assign start_rise = start_s & ~start_prev;
  assign start_fall = ~start_s & start_prev;

  // Channel latch is transparent while ale_s is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q <= 3'd0;
    end else if (ale_s) begin
      ch_q <= addr;
    end
  end

  assign conv_done = (state_q == StConvert) && !start_rise && (cnt_q == ConvLast);

`ifdef ADC_EMU_RAMP_EN
  logic [7:0] ramp_q [8];
  logic [2:0] hold_ch_q;

  assign sample = ramp_q[ch_q];

  // Remember which ramp produced the held sample so ale activity mid-conversion cannot
  // redirect the increment to another channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_ch_q <= 3'd0;
    end else if (state_q == StArm && start_fall) begin
      hold_ch_q <= ch_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) ramp_q[i] <= 8'h00;
    end else if (conv_done) begin
      ramp_q[hold_ch_q] <= ramp_q[hold_ch_q] + 8'(RAMP_STEP);
    end
  end
`else
  logic unused_ramp_step;
  assign unused_ramp_step = ^(32'(RAMP_STEP));
  assign sample = ch_data[{ch_q, 3'b000} +: 8];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      dly_q      <= 8'd0;
      cnt_q      <= 16'd0;
      eoc_q      <= 1'b1;
      busy_q     <= 1'b0;
      data_q     <= 8'h00;
      conv_cnt_q <= 16'd0;
      hold_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      cnt_q      <= cnt_d;
      eoc_q      <= eoc_d;
      busy_q     <= busy_d;
      data_q     <= data_d;
      conv_cnt_q <= conv_cnt_d;
      hold_q     <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    cnt_d      = cnt_q;
    eoc_d      = eoc_q;
    busy_d     = busy_q;
    data_d     = data_q;
    conv_cnt_d = conv_cnt_q;
    hold_d     = hold_q;
    unique case (state_q)
      StIdle: begin
        eoc_d  = 1'b1;
        busy_d = 1'b0;
        if (start_rise) begin
          dly_d   = 8'd0;
          busy_d  = 1'b1;
          state_d = StArm;
        end
      end
      StArm: begin
        // Delay counter saturates at EOC_DLY; eoc drops on the cycle it gets there.
        if (dly_q != EocDly) begin
          dly_d = dly_q + 8'd1;
          if (dly_d == EocDly) eoc_d = 1'b0;
        end
        if (start_fall) begin
          eoc_d   = 1'b0;
          hold_d  = sample;
          cnt_d   = 16'd0;
          state_d = StConvert;
        end
      end
      StConvert: begin
        eoc_d = 1'b0;
        if (start_rise) begin
          // Abort: restart arming, leave published results untouched.
          dly_d   = 8'd0;
          state_d = StArm;
        end else if (conv_done) begin
          data_d     = hold_q;
          eoc_d      = 1'b1;
          busy_d     = 1'b0;
          conv_cnt_d = conv_cnt_q + 16'd1;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign eoc      = eoc_q;
  assign busy     = busy_q;
  assign data_out = data_q;
  assign conv_cnt = conv_cnt_q;
  assign data_drv = oe;

endmodule
